// File: rtl/serial_uart_pkg.sv
// rtl/serial_uart_pkg.sv - shared constants and FSM state encoding for the UART port
package serial_uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uartState_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, depth 2**AW, extra pointer bit for full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             empty,
  output logic             full
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop   = pop && !empty;
  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign doPush  = push && (!full || pop);
  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/serial_uart_port.sv
// rtl/serial_uart_port.sv - bridges the processor serial byte handshake to an 8N1 UART line
module serial_uart_port
  import serial_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rd_en_in,
  output logic       tx_ready_out,
  input  logic [7:0] tx_data_in,
  input  logic       wr_en_in,
  input  logic       uart_rxd_in,
  output logic       uart_txd_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  logic       txEmpty, txFull, txPop;
  logic [7:0] txHead;
  logic       rxEmpty, rxFull, rxPush;
  logic [7:0] rxHead;

  sync_fifo #(.WIDTH(UART_DATA_BITS), .AW(FIFO_AW)) txFifo (
    .clock(clock), .reset(reset), .push(wr_en_in), .pushData(tx_data_in),
    .pop(txPop), .popData(txHead), .empty(txEmpty), .full(txFull)
  );

  uartState_t        txState, txStateNext;
  logic [BAUD_W-1:0] txBaud, txBaudNext;
  logic [2:0]        txBit, txBitNext;
  logic [7:0]        txShift, txShiftNext;

  always_comb begin
    txStateNext = txState;
    txBaudNext  = txBaud;
    txBitNext   = txBit;
    txShiftNext = txShift;
    txPop       = 1'b0;
    case (txState)
      ST_IDLE: if (!txEmpty) begin
        txPop       = 1'b1;
        txShiftNext = txHead;
        txBaudNext  = '0;
        txStateNext = ST_START;
      end
      ST_START: if (txBaud == BAUD_LAST) begin
        txBaudNext  = '0;
        txBitNext   = '0;
        txStateNext = ST_DATA;
      end else txBaudNext = txBaud + 1'b1;
      ST_DATA: if (txBaud == BAUD_LAST) begin
        txBaudNext  = '0;
        txShiftNext = {1'b0, txShift[7:1]};
        if (txBit == BIT_LAST) txStateNext = ST_STOP;
        else txBitNext = txBit + 1'b1;
      end else txBaudNext = txBaud + 1'b1;
      ST_STOP: if (txBaud == BAUD_LAST) begin
        txBaudNext = '0;
        // Chain straight into the next frame when more data is queued.
        if (!txEmpty) begin
          txPop       = 1'b1;
          txShiftNext = txHead;
          txStateNext = ST_START;
        end else txStateNext = ST_IDLE;
      end else txBaudNext = txBaud + 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      txState      <= ST_IDLE;
      txBaud       <= '0;
      txBit        <= '0;
      txShift      <= '0;
      uart_txd_out <= UART_IDLE_LEVEL;
    end else begin
      txState      <= txStateNext;
      txBaud       <= txBaudNext;
      txBit        <= txBitNext;
      txShift      <= txShiftNext;
      uart_txd_out <= (txStateNext == ST_START) ? ~UART_IDLE_LEVEL :
                      (txStateNext == ST_DATA)  ? txShiftNext[0] : UART_IDLE_LEVEL;
    end
  end

  logic [1:0]        rxSync;
  logic              rxLine;
  uartState_t        rxState, rxStateNext;
  logic [BAUD_W-1:0] rxBaud, rxBaudNext;
  logic [2:0]        rxBit, rxBitNext;
  logic [7:0]        rxShift, rxShiftNext;
  logic              rxErrWait, rxErrWaitNext;
  logic              setOverrun, setFrameErr;

  assign rxLine = rxSync[1];

  always_comb begin
    rxStateNext   = rxState;
    rxBaudNext    = rxBaud;
    rxBitNext     = rxBit;
    rxShiftNext   = rxShift;
    rxErrWaitNext = rxErrWait;
    rxPush        = 1'b0;
    setOverrun    = 1'b0;
    setFrameErr   = 1'b0;
    case (rxState)
      ST_IDLE: if (rxLine != UART_IDLE_LEVEL) begin
        rxBaudNext  = '0;
        rxStateNext = ST_START;
      end
      ST_START: if (rxBaud == BAUD_HALF) begin
        rxBaudNext  = '0;
        rxBitNext   = '0;
        rxStateNext = (rxLine == UART_IDLE_LEVEL) ? ST_IDLE : ST_DATA;
      end else rxBaudNext = rxBaud + 1'b1;
      ST_DATA: if (rxBaud == BAUD_LAST) begin
        rxBaudNext  = '0;
        rxShiftNext = {rxLine, rxShift[7:1]};
        if (rxBit == BIT_LAST) rxStateNext = ST_STOP;
        else rxBitNext = rxBit + 1'b1;
      end else rxBaudNext = rxBaud + 1'b1;
      ST_STOP: if (rxErrWait) begin
        // Broken frame: hold off until the line idles again.
        if (rxLine == UART_IDLE_LEVEL) begin
          rxErrWaitNext = 1'b0;
          rxStateNext   = ST_IDLE;
        end
      end else if (rxBaud == BAUD_LAST) begin
        rxBaudNext = '0;
        if (rxLine == UART_IDLE_LEVEL) begin
          rxStateNext = ST_IDLE;
          if (rxFull && !rd_en_in) setOverrun = 1'b1;
          else rxPush = 1'b1;
        end else begin
          setFrameErr   = 1'b1;
          rxErrWaitNext = 1'b1;
        end
      end else rxBaudNext = rxBaud + 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rxSync           <= {2{UART_IDLE_LEVEL}};
      rxState          <= ST_IDLE;
      rxBaud           <= '0;
      rxBit            <= '0;
      rxShift          <= '0;
      rxErrWait        <= 1'b0;
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
    end else begin
      rxSync    <= {rxSync[0], uart_rxd_in};
      rxState   <= rxStateNext;
      rxBaud    <= rxBaudNext;
      rxBit     <= rxBitNext;
      rxShift   <= rxShiftNext;
      rxErrWait <= rxErrWaitNext;
      if (setOverrun)  rx_overrun_out   <= 1'b1;
      if (setFrameErr) rx_frame_err_out <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(UART_DATA_BITS), .AW(FIFO_AW)) rxFifo (
    .clock(clock), .reset(reset), .push(rxPush), .pushData(rxShift),
    .pop(rd_en_in), .popData(rxHead), .empty(rxEmpty), .full(rxFull)
  );

  assign rx_valid_out = !rxEmpty;
  assign rx_data_out  = rxEmpty ? 8'h00 : rxHead;
  assign tx_ready_out = !txFull;

endmodule

// File: doc/serial_uart_port.md
Name: serial_uart_port

Overview:
Peripheral that terminates the processor's byte-wide serial IO handshake, i.e. the other end of the data memory's serial_in/serial_valid_in/serial_ready_in/serial_out/serial_rden_out/serial_wren_out ports. It converts that interface to a physical 8N1 UART line. Two buffered directions, each with its own FIFO:
- TX: processor writes bytes, which are serialised onto uart_txd_out.
- RX: bytes deserialised from uart_rxd_in are queued for the processor to read.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
FIFO_AW, 2, log2 of each FIFO's depth (default depth 4).

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
rx_data_out  output  8  head byte of RX FIFO; wires to processor serial_in.
rx_valid_out  output  1  RX FIFO non-empty; wires to serial_valid_in.
rd_en_in  input  1  pop RX head this cycle; wires from serial_rden_out.
tx_ready_out  output  1  TX FIFO not full; wires to serial_ready_in.
tx_data_in  input  8  byte to transmit; wires from serial_out.
wr_en_in  input  1  push tx_data_in this cycle; wires from serial_wren_out.
uart_rxd_in  input  1  asynchronous UART receive line, idle high.
uart_txd_out  output  1  UART transmit line, idle high.
rx_overrun_out  output  1  sticky: a received byte was dropped because the RX FIFO was full; cleared only by reset.
rx_frame_err_out  output  1  sticky: a stop bit was sampled low; cleared only by reset.

Behaviour:
Reset values:
- FIFOs empty.
- rx_valid_out=0, rx_data_out=0, tx_ready_out=1.
- uart_txd_out=1, both sticky flags=0.
- Both FSMs in IDLE; bit and baud counters at 0.
- Reset mid-frame aborts the frame immediately; txd returns high the next cycle.

FIFO rules:
- Push when full is ignored; pop when empty is ignored.
- Simultaneous push and pop are both honoured, including at full and at empty (at empty, the pop is a no-op).
- rx_data_out is valid whenever rx_valid_out=1 and is stable until popped.
- Pointers wrap modulo 2^FIFO_AW; occupancy is tracked with an extra pointer bit.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: when the TX FIFO is non-empty, pop the head into a shift register and go to START.
- If wr_en_in arrives in cycle N with TX idle and the FIFO empty, the start bit (txd=0) first appears in cycle N+2.
- START, each DATA bit and STOP each hold for exactly CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, bit counter 0..7.
- STOP: txd=1, then return to IDLE. If the FIFO is non-empty at the end of STOP, the next start bit follows immediately with no extra idle cycle.
- Frame length is exactly 10*CLKS_PER_BIT cycles.

RX path:
- uart_rxd_in passes through a 2-flop synchroniser before any use.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE: a synchronised low starts the half-bit counter.
- START: re-sample at CLKS_PER_BIT/2 (integer divide). If high, treat as a glitch and return to IDLE. Otherwise continue.
- DATA: sample each data bit at its midpoint, every CLKS_PER_BIT cycles; shift in LSB first.
- STOP: sample at mid-stop.
  - High and FIFO not full: push the byte; rx_valid_out rises the next cycle.
  - High and FIFO full, with no pop that cycle: drop the byte and set rx_overrun_out. A same-cycle pop frees space, so the byte is pushed.
  - Low: drop the byte, set rx_frame_err_out, and wait in STOP until the line is high before returning to IDLE.
- The RX FSM returns to IDLE right after a valid mid-stop sample, so a following start edge is detected within the remaining half bit.

Other rules:
- Baud counters count 0..CLKS_PER_BIT-1 and are sized $clog2(CLKS_PER_BIT).
- No combinational path from any input to any output except FIFO flag/data reads, which are registered-state-derived.

Decomposition:
- Shared package serial_uart_pkg:
  - constants UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1;
  - 2-bit state encodings ST_IDLE, ST_START, ST_DATA, ST_STOP, used by both FSMs.
- One sub-module: sync_fifo (width 8, parameter AW), instantiated twice (TX and RX).
- The TX and RX FSMs stay inline in serial_uart_port.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
1. Reset, then idle 50 cycles -> uart_txd_out=1 throughout, tx_ready_out=1, rx_valid_out=0, both flags 0.
2. wr_en_in with 0xA5 in cycle N -> txd low in cycles N+2..N+5, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high; total frame 40 cycles.
3. Five back-to-back writes 0x01..0x05 while TX is busy -> tx_ready_out drops after the FIFO holds 4; the fifth write is ignored only if issued while tx_ready_out=0; the accepted bytes appear on the line in order with no idle gap between frames.
4. Drive an 8N1 frame for 0x3C into uart_rxd_in -> rx_valid_out=1, rx_data_out=0x3C; a rd_en_in pulse -> rx_valid_out=0 the next cycle.
5. Receive 5 frames 0x10..0x14 with no reads -> FIFO holds 0x10..0x13, rx_overrun_out=1, and 4 pops return 0x10..0x13.
6. Frame 0x55 with stop bit low -> nothing pushed, rx_frame_err_out=1; a 1-cycle low glitch on an idle line -> no byte and no flag set.
